mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
//  Producer side of the 8x8 MAC operand interface: buffers operand pairs written by the host,
//  streams them to a MAC unit as a burst (mac_a/mac_b plus mac_en), then captures the accumulated
//  16-bit result. Returns it on a valid/ready result port. Sits between host/control logic and the MAC.
// PARAMETERS
//  DEPTH      8  operand-pair buffer entries (power of 2, >=2); max pairs per burst
//  DRAIN_CYC  2  cycles after mac_en falls until mac_c holds the final sum; mac_c sampled at end of last
//  CW         4  count width = $clog2(DEPTH)+1
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  reset      in   1   synchronous, active-high reset
//  wr_valid   in   1   host operand pair valid
//  wr_a       in   8   operand A (unsigned)
//  wr_b       in   8   operand B (unsigned)
//  wr_ready   out  1   pair accepted this cycle when wr_valid&wr_ready
//  start      in   1   begin burst over all buffered pairs (single-cycle pulse)
//  busy       out  1   high in STREAM, DRAIN, DONE
//  mac_en     out  1   MAC accumulate enable
//  mac_a      out  8   operand A to MAC
//  mac_b      out  8   operand B to MAC
//  mac_c      in   16  MAC registered result
//  res_valid  out  1   result available
//  res_data   out  16  captured sum, modulo 2^16
//  res_count  out  CW  number of pairs in the burst
//  res_ready  in   1   host takes result when res_valid&res_ready
// BEHAVIOUR
//  - Reset: state IDLE, buffer empty, all outputs 0 except wr_ready=1. Reset mid-burst aborts it and
//    discards buffered pairs and any pending result; mac_en drops in the cycle after reset.
//  - FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE: wr_ready = !full. Writes while full are dropped; buffer unchanged.
//    start with count>0 latches N=count and enters STREAM next cycle.
//    start with count==0 is ignored. start with a simultaneous write: the write is included in N.
//  - STREAM lasts N+1 cycles s0..sN. In cycle sk (k<N), mac_a/mac_b = pair k in FIFO order.
//    mac_en=1 in s1..sN: one cycle behind the operands to match the MAC input register stage.
//    In sN, mac_a/mac_b=0.
//  - DRAIN: mac_en=0 and operands 0 for DRAIN_CYC cycles. mac_c is registered into res_data at the
//    edge ending the last DRAIN cycle. res_count=N.
//  - DONE: res_valid=1. res_data/res_count held stable until res_valid&res_ready, then back to IDLE
//    with the buffer empty. Backpressure is unlimited.
//  - wr_ready=0 and start ignored whenever busy. Outside STREAM, mac_en=0 and mac_a=mac_b=0.
//  - Arithmetic is done by the MAC. Overflow wraps mod 2^16 and is reported as-is, no saturation.
//  - Buffer pointers wrap at DEPTH. full when count==DEPTH. Max burst = DEPTH pairs.
// STRUCTURE
//  - Shared package mac_pkg: state enum (IDLE/STREAM/DRAIN/DONE), OP_W=8, ACC_W=16 constants.
//  - Sub-module mac_operand_fifo: DEPTH x 16-bit synchronous FIFO with push/pop/count/full/empty and
//    synchronous active-high reset.
//  - Top holds the FSM, stream counter, drain counter and result register.
// TESTING
//  1 write (3,4),(5,6); start -> mac_en high 2 cycles; with MAC model res_data=42, res_count=2
//  2 write 8 x (255,255); 9th write while full -> dropped, wr_ready=0; start -> res_data=61448 (wrap),
//    res_count=8
//  3 start with empty buffer -> no state change, busy=0, mac_en stays 0
//  4 hold res_ready=0 for 20 cycles in DONE -> res_valid/res_data stable; wr_ready=0; start ignored
//  5 assert reset in STREAM cycle s1 -> next cycle mac_en=0, res_valid=0, wr_ready=1, buffer empty
//  6 write (7,9) in same cycle as start with 1 pair (2,2) buffered -> res_count=2, res_data=67

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand sequencer and its buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;

    // Sequencer states. Kept as plain constants so older tools and netlists can decode them.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // One buffered operand pair; A occupies the upper byte.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Host and MAC facing signals of the operand sequencer, bundled for one port connection.
// Latency: n/a (wiring only).
// Backpressure: wr_ready gates host writes, res_ready holds the result indefinitely.
interface mac_operand_sequencer_if #(
    parameter int CW = 4
);
    import mac_pkg::*;

    // Host operand write channel
    logic             wr_valid;
    logic [OP_W-1:0]  wr_a;
    logic [OP_W-1:0]  wr_b;
    logic             wr_ready;

    // Burst control
    logic             start;
    logic             busy;

    // MAC unit side
    logic             mac_en;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic [ACC_W-1:0] mac_c;

    // Result channel
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic [CW-1:0]    res_count;
    logic             res_ready;

    // Host / MAC environment: drives operands, start, the MAC result and result ready.
    modport master (
        output wr_valid, wr_a, wr_b, start, mac_c, res_ready,
        input  wr_ready, busy, mac_en, mac_a, mac_b, res_valid, res_data, res_count
    );

    // Sequencer itself.
    modport slave (
        input  wr_valid, wr_a, wr_b, start, mac_c, res_ready,
        output wr_ready, busy, mac_en, mac_a, mac_b, res_valid, res_data, res_count
    );

endinterface

// File: rtl/mac_operand_fifo.sv
// DEPTH x W synchronous FIFO holding operand pairs between host writes and the MAC stream.
// Latency: a pushed word is visible on pop_dat from the cycle after the push (show-ahead read).
// Backpressure: push is ignored while full and pop is ignored while empty.
module mac_operand_fifo #(
    parameter int  DEPTH = 8,
    parameter int  W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage write and pointer/occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register storage and pointers; reset empties the buffer and clears stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Buffers host operand pairs, streams them to an 8x8 MAC as one burst and returns the captured sum.
// Latency: start -> result valid after N+1 stream cycles plus DRAIN_CYC drain cycles.
// Backpressure: writes stall (wr_ready=0) when full or busy; the result is held until res_ready.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  DRAIN_CYC = 2,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mac_operand_sequencer_if.slave bus
);

    localparam int            DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      n_q, n_d;            // pairs in the current burst
    logic [CW-1:0]      k_q, k_d;            // stream cycle index s0..sN
    logic [DW-1:0]      drain_q, drain_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;

    op_pair_t           wr_pair;
    op_pair_t           rd_pair;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      burst_len;
    logic               wr_ready;
    logic               operand_phase;

    // Writes are only taken while idle, so the buffer cannot change under a running burst.
    assign wr_ready  = (state_q == ST_IDLE) && !fifo_full;
    assign fifo_push = bus.wr_valid && wr_ready;
    assign wr_pair   = {bus.wr_a, bus.wr_b};

    // A write landing in the same cycle as start belongs to this burst; push never overflows N.
    assign burst_len = fifo_count + CW'(fifo_push);

    // Cycles s0..s(N-1) present one buffered pair each; sN carries no operands.
    assign operand_phase = (state_q == ST_STREAM) && (k_q < n_q) && !fifo_empty;
    assign fifo_pop      = operand_phase;

    mac_operand_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OP_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (wr_pair),
        .pop      (fifo_pop),
        .pop_dat  (rd_pair),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = (state_q != ST_IDLE);
    // Enable trails the operands by one cycle to line up with the MAC's input register stage.
    assign bus.mac_en    = (state_q == ST_STREAM) && (k_q != '0);
    assign bus.mac_a     = operand_phase ? rd_pair.a : '0;
    assign bus.mac_b     = operand_phase ? rd_pair.b : '0;
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_count = n_q;

    // Burst sequencing: latch N on start, count stream and drain cycles, capture mac_c, wait for host.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        drain_d    = drain_q;
        res_data_d = res_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (burst_len != '0)) begin
                    n_d     = burst_len;
                    k_d     = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (k_q == n_q) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    // mac_c has settled on the final sum by the end of the last drain cycle.
                    res_data_d = bus.mac_c;
                    state_d    = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any burst and any unread result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            res_data_q <= res_data_d;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer with a simple registered-input MAC attached.
// Latency: n/a.
// Backpressure: exercised by holding res_ready low and by writing into a full buffer.
module tb_mac_operand_sequencer;

    localparam int DEPTH     = 8;
    localparam int DRAIN_CYC = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          en_total = 0;
    logic [15:0] model_q[$];          // accepted pairs, {a, b}, in arrival order

    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.CW(CW)) bus ();

    mac_operand_sequencer #(
        .DEPTH     (DEPTH),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External MAC: operands registered once, then accumulated while mac_en is high.
    // A fresh enable run starts a new sum.
    logic [7:0]  mac_a_r  = '0;
    logic [7:0]  mac_b_r  = '0;
    logic        mac_en_r = 1'b0;
    logic [15:0] acc_r    = '0;

    always @(posedge clk) begin
        mac_a_r  <= bus.mac_a;
        mac_b_r  <= bus.mac_b;
        mac_en_r <= bus.mac_en;
        if (bus.mac_en === 1'b1) begin
            acc_r    <= (mac_en_r ? acc_r : 16'd0) + ({8'd0, mac_a_r} * {8'd0, mac_b_r});
            en_total <= en_total + 1;
        end
    end

    assign bus.mac_c = acc_r;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Host write in IDLE; the reference keeps a pair only if there was room for it.
    task automatic write_pair(input logic [7:0] a, input logic [7:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_a     = a;
        bus.wr_b     = b;
        if (model_q.size() < DEPTH) model_q.push_back({a, b});
        step();
        bus.wr_valid = 1'b0;
    endtask

    // Reference result of a burst: sum of products mod 2^16 over everything buffered.
    task automatic model_take(output logic [15:0] sum, output int n);
        logic [15:0] pa;
        logic [15:0] pb;
        sum = '0;
        n   = model_q.size();
        foreach (model_q[i]) begin
            pa  = {8'd0, model_q[i][15:8]};
            pb  = {8'd0, model_q[i][7:0]};
            sum = sum + pa * pb;
        end
        model_q.delete();
    endtask

    // Pulse start (optionally with a same-cycle write) and wait, bounded, for the result.
    task automatic run_burst(input logic with_wr, input logic [7:0] a, input logic [7:0] b,
                             output logic [15:0] got_data, output logic [CW-1:0] got_cnt,
                             output int got_en, output logic got_vld);
        int en0;
        en0 = en_total;
        if (with_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_a     = a;
            bus.wr_b     = b;
            if (model_q.size() < DEPTH) model_q.push_back({a, b});
        end
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 200 && bus.res_valid !== 1'b1; i++) step();
        got_vld  = bus.res_valid;
        got_data = bus.res_data;
        got_cnt  = bus.res_count;
        got_en   = en_total - en0;
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [CW+35:0] exp_v;
        exp_v = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 16'd0, {CW{1'b0}}};
        step();
        step();
        n_checks++;
        if ({bus.wr_ready, bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid, bus.res_data, bus.res_count} !== exp_v)
            $display("FAIL reset_in: got rdy=%b busy=%b en=%b a=%h b=%h vld=%b data=%h cnt=%h want %h",
                     bus.wr_ready, bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid, bus.res_data, bus.res_count, exp_v);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if ({bus.wr_ready, bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid, bus.res_data, bus.res_count} !== exp_v)
            $display("FAIL reset_out: got rdy=%b busy=%b en=%b a=%h b=%h vld=%b want %h",
                     bus.wr_ready, bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid, exp_v);
        else n_pass++;
    endtask

    task automatic test_basic();
        write_pair(8'd3, 8'd4);
        write_pair(8'd5, 8'd6);
        model_q.delete();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.mac_en, bus.mac_a, bus.mac_b} !== {1'b1, 1'b0, 8'd3, 8'd4})
            $display("FAIL basic_s0: got busy=%b en=%b a=%0d b=%0d want 1 0 3 4", bus.busy, bus.mac_en, bus.mac_a, bus.mac_b);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.busy, bus.mac_en, bus.mac_a, bus.mac_b} !== {1'b1, 1'b1, 8'd5, 8'd6})
            $display("FAIL basic_s1: got busy=%b en=%b a=%0d b=%0d want 1 1 5 6", bus.busy, bus.mac_en, bus.mac_a, bus.mac_b);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.busy, bus.mac_en, bus.mac_a, bus.mac_b} !== {1'b1, 1'b1, 8'd0, 8'd0})
            $display("FAIL basic_s2: got busy=%b en=%b a=%0d b=%0d want 1 1 0 0", bus.busy, bus.mac_en, bus.mac_a, bus.mac_b);
        else n_pass++;
        for (int d = 0; d < DRAIN_CYC; d++) begin
            step();
            n_checks++;
            if ({bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0})
                $display("FAIL basic_drain%0d: got busy=%b en=%b a=%0d b=%0d vld=%b want 1 0 0 0 0",
                         d, bus.busy, bus.mac_en, bus.mac_a, bus.mac_b, bus.res_valid);
            else n_pass++;
        end
        step();
        n_checks++;
        if ({bus.res_valid, bus.res_data, bus.res_count} !== {1'b1, 16'd42, CW'(2)})
            $display("FAIL basic_result: got vld=%b data=%0d cnt=%0d want 1 42 2", bus.res_valid, bus.res_data, bus.res_count);
        else n_pass++;
        take_result();
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL basic_idle: got busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_full_wrap();
        logic [15:0]   exp_sum;
        logic [15:0]   got_data;
        logic [CW-1:0] got_cnt;
        int            exp_n;
        int            got_en;
        logic          got_vld;
        for (int i = 0; i < DEPTH; i++) write_pair(8'd255, 8'd255);
        n_checks++;
        if (bus.wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", bus.wr_ready);
        else n_pass++;
        write_pair(8'd1, 8'd1);
        run_burst(1'b0, 8'd0, 8'd0, got_data, got_cnt, got_en, got_vld);
        model_take(exp_sum, exp_n);
        n_checks++;
        if ({got_vld, got_data, got_cnt} !== {1'b1, exp_sum, CW'(exp_n)})
            $display("FAIL full_result: got vld=%b data=%0d cnt=%0d want 1 %0d %0d", got_vld, got_data, got_cnt, exp_sum, exp_n);
        else n_pass++;
        n_checks++;
        if (got_en !== exp_n) $display("FAIL full_en_cycles: got %0d want %0d", got_en, exp_n);
        else n_pass++;
        take_result();
    endtask

    task automatic test_empty_start();
        int en0;
        en0 = en_total;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.mac_en} !== 2'b00) $display("FAIL empty_start: got busy=%b en=%b want 0 0", bus.busy, bus.mac_en);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({bus.busy, bus.wr_ready} !== 2'b01 || en_total != en0)
            $display("FAIL empty_quiet: got busy=%b rdy=%b en_cycles=%0d want 0 1 0", bus.busy, bus.wr_ready, en_total - en0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0]   exp_sum;
        logic [15:0]   got_data;
        logic [CW-1:0] got_cnt;
        int            exp_n;
        int            got_en;
        logic          got_vld;
        for (int i = 0; i < 3; i++) write_pair(8'($urandom), 8'($urandom));
        run_burst(1'b0, 8'd0, 8'd0, got_data, got_cnt, got_en, got_vld);
        model_take(exp_sum, exp_n);
        n_checks++;
        if ({got_vld, got_data} !== {1'b1, exp_sum}) $display("FAIL bp_result: got vld=%b data=%0d want 1 %0d", got_vld, got_data, exp_sum);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            bus.start    = c[0];
            bus.wr_valid = ~c[0];
            bus.wr_a     = 8'($urandom);
            bus.wr_b     = 8'($urandom);
            n_checks++;
            if ({bus.res_valid, bus.res_data, bus.res_count, bus.wr_ready, bus.busy} !== {1'b1, exp_sum, CW'(exp_n), 1'b0, 1'b1})
                $display("FAIL bp_hold%0d: got vld=%b data=%0d cnt=%0d rdy=%b busy=%b want 1 %0d %0d 0 1",
                         c, bus.res_valid, bus.res_data, bus.res_count, bus.wr_ready, bus.busy, exp_sum, exp_n);
            else n_pass++;
            step();
        end
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        take_result();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL bp_buffer_empty: got busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0]   exp_sum;
        logic [15:0]   got_data;
        logic [CW-1:0] got_cnt;
        int            exp_n;
        int            got_en;
        logic          got_vld;
        for (int i = 0; i < 3; i++) write_pair(8'($urandom), 8'($urandom));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        n_checks++;
        if (bus.mac_en !== 1'b1) $display("FAIL rst_s1_en: got %b want 1", bus.mac_en);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_q.delete();
        n_checks++;
        if ({bus.mac_en, bus.res_valid, bus.wr_ready, bus.busy} !== 4'b0010)
            $display("FAIL rst_after: got en=%b vld=%b rdy=%b busy=%b want 0 0 1 0", bus.mac_en, bus.res_valid, bus.wr_ready, bus.busy);
        else n_pass++;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL rst_buffer_empty: got busy=%b want 0", bus.busy);
        else n_pass++;
        write_pair(8'd11, 8'd13);
        run_burst(1'b0, 8'd0, 8'd0, got_data, got_cnt, got_en, got_vld);
        model_take(exp_sum, exp_n);
        n_checks++;
        if ({got_vld, got_data, got_cnt} !== {1'b1, exp_sum, CW'(exp_n)})
            $display("FAIL rst_recover: got vld=%b data=%0d cnt=%0d want 1 %0d %0d", got_vld, got_data, got_cnt, exp_sum, exp_n);
        else n_pass++;
        take_result();
    endtask

    task automatic test_start_with_write();
        logic [15:0]   exp_sum;
        logic [15:0]   got_data;
        logic [CW-1:0] got_cnt;
        int            exp_n;
        int            got_en;
        logic          got_vld;
        write_pair(8'd2, 8'd2);
        run_burst(1'b1, 8'd7, 8'd9, got_data, got_cnt, got_en, got_vld);
        model_take(exp_sum, exp_n);
        n_checks++;
        if ({got_vld, got_data, got_cnt} !== {1'b1, exp_sum, CW'(exp_n)})
            $display("FAIL sw_result: got vld=%b data=%0d cnt=%0d want 1 %0d %0d", got_vld, got_data, got_cnt, exp_sum, exp_n);
        else n_pass++;
        n_checks++;
        if (got_en !== exp_n) $display("FAIL sw_en_cycles: got %0d want %0d", got_en, exp_n);
        else n_pass++;
        take_result();
    endtask

    task automatic test_random();
        logic [15:0]   exp_sum;
        logic [15:0]   got_data;
        logic [CW-1:0] got_cnt;
        int            exp_n;
        int            got_en;
        logic          got_vld;
        int            nw;
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(1, DEPTH + 2);
            for (int w = 0; w < nw; w++) begin
                write_pair(8'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) step();
            end
            run_burst($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), got_data, got_cnt, got_en, got_vld);
            model_take(exp_sum, exp_n);
            n_checks++;
            if (got_vld !== 1'b1) $display("FAIL rnd%0d_valid: got %b want 1 (timeout)", it, got_vld);
            else n_pass++;
            n_checks++;
            if (got_data !== exp_sum) $display("FAIL rnd%0d_data: got %0d want %0d", it, got_data, exp_sum);
            else n_pass++;
            n_checks++;
            if (got_cnt !== CW'(exp_n)) $display("FAIL rnd%0d_count: got %0d want %0d", it, got_cnt, exp_n);
            else n_pass++;
            n_checks++;
            if (got_en !== exp_n) $display("FAIL rnd%0d_en_cycles: got %0d want %0d", it, got_en, exp_n);
            else n_pass++;
            repeat ($urandom_range(0, 4)) step();
            take_result();
            n_checks++;
            if (bus.busy !== 1'b0) $display("FAIL rnd%0d_idle: got busy=%b want 0", it, bus.busy);
            else n_pass++;
        end
    endtask

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_a      = '0;
        bus.wr_b      = '0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_empty_start();
        test_backpressure();
        test_reset_mid_burst();
        test_start_with_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
